// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam logic [1:0] IDLE_CODE = 2'd0;
  localparam logic [1:0] RUN_CODE  = 2'd1;
  localparam logic [1:0] FIX_CODE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = IDLE_CODE,
    RUN  = RUN_CODE,
    FIX  = FIX_CODE
  } state_e;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_mag.sv
// Operand magnitude/sign split; in unsigned mode the raw value passes through.
module mul_mag #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] magnitude,
  output logic             sign
);

  assign sign = signed_mode & value[WIDTH-1];
  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign magnitude = sign ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mul_seq_signed.sv
// Sequential signed/unsigned shift-and-add multiplier, WIDTH+1 cycle latency.
//
// state | meaning
// IDLE  | waiting for start, result held
// RUN   | one shift-and-add iteration per cycle, cnt counts down from WIDTH
// FIX   | apply sign to accumulator, write result, pulse done
module mul_seq_signed
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               sign_a;
  logic               sign_b;

  mul_mag #(.WIDTH(WIDTH)) u_mag_a (
    .value       (a),
    .signed_mode (signed_mode),
    .magnitude   (mag_a),
    .sign        (sign_a)
  );

  mul_mag #(.WIDTH(WIDTH)) u_mag_b (
    .value       (b),
    .signed_mode (signed_mode),
    .magnitude   (mag_b),
    .sign        (sign_b)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= sign_a ^ sign_b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          result <= neg ? -acc : acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_signed.sv
// Self-checking bench: WIDTH=4, 8 and 16 instances against an arithmetic product model.
module tb_mul_seq_signed;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_v [3];
  logic        sm_v    [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];

  logic [7:0]  r4;
  logic [15:0] r8;
  logic [31:0] r16;
  logic        d4, d8, d16;
  logic        y4, y8, y16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq_signed #(.WIDTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .start(start_v[0]), .signed_mode(sm_v[0]),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .result(r4), .done(d4), .busy(y4)
  );

  mul_seq_signed #(.WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .start(start_v[1]), .signed_mode(sm_v[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .result(r8), .done(d8), .busy(y8)
  );

  mul_seq_signed #(.WIDTH(16)) dut16 (
    .clk(clk), .rstn(rstn), .start(start_v[2]), .signed_mode(sm_v[2]),
    .a(a_v[2]), .b(b_v[2]), .result(r16), .done(d16), .busy(y16)
  );

  function automatic int width_of(input int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 8 : 16;
  endfunction

  function automatic logic [31:0] get_res(input int sel);
    return (sel == 0) ? {24'd0, r4} : (sel == 1) ? {16'd0, r8} : r16;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? d4 : (sel == 1) ? d8 : d16;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? y4 : (sel == 1) ? y8 : y16;
  endfunction

  // Reference: interpret operands as integers, multiply, truncate to 2*w bits.
  function automatic logic [31:0] ref_prod(input int w, input bit sm,
                                           input logic [15:0] a, input logic [15:0] b);
    longint av, bv, p, mask;
    mask = (longint'(1) << w) - 1;
    av = longint'(a) & mask;
    bv = longint'(b) & mask;
    if (sm && a[w-1]) av = av - (longint'(1) << w);
    if (sm && b[w-1]) bv = bv - (longint'(1) << w);
    p = av * bv;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Issues one operation and measures it; scribbles start/operands while busy.
  task automatic run_op(input int sel, input bit sm, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] res, output int lat, output bit stable,
                        output logic done_after, output logic [31:0] res_after);
    logic [31:0] prev;
    prev = get_res(sel);
    stable = 1'b1;
    start_v[sel] = 1'b1; sm_v[sel] = sm; a_v[sel] = a; b_v[sel] = b;
    @(posedge clk); #1;
    lat = 0;
    while (!get_done(sel) && lat < 40) begin
      if (get_res(sel) !== prev) stable = 1'b0;
      start_v[sel] = 1'($urandom);
      sm_v[sel]    = 1'($urandom);
      a_v[sel]     = 16'($urandom);
      b_v[sel]     = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    start_v[sel] = 1'b0;
    res = get_res(sel);
    @(posedge clk); #1;
    done_after = get_done(sel);
    res_after  = get_res(sel);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (get_res(s) !== 32'd0) begin
        errors++; $display("FAIL reset_result w=%0d got=%h exp=0", width_of(s), get_res(s));
      end
      checks++;
      if (get_done(s) !== 1'b0) begin
        errors++; $display("FAIL reset_done w=%0d got=%b exp=0", width_of(s), get_done(s));
      end
      checks++;
      if (get_busy(s) !== 1'b0) begin
        errors++; $display("FAIL reset_busy w=%0d got=%b exp=0", width_of(s), get_busy(s));
      end
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_w4_example();
    logic [31:0] res, res_after;
    int lat; bit stable; logic done_after;
    run_op(0, 1'b1, 16'h000D, 16'h0009, res, lat, stable, done_after, res_after);
    checks++;
    if (res !== 32'h15) begin
      errors++; $display("FAIL w4_result got=%h exp=15", res);
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL w4_latency got=%0d exp=5", lat);
    end
    checks++;
    if (done_after !== 1'b0) begin
      errors++; $display("FAIL w4_done_pulse got=%b exp=0", done_after);
    end
  endtask

  task automatic test_corners();
    logic [15:0] ta [5] = '{16'h80, 16'h80, 16'h00, 16'hFF, 16'hFF};
    logic [15:0] tb [5] = '{16'h80, 16'h7F, 16'hFB, 16'hFF, 16'hFF};
    bit          tm [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] te [5] = '{32'h4000, 32'hC080, 32'h0000, 32'hFE01, 32'h0001};
    logic [31:0] res, res_after;
    int lat; bit stable; logic done_after;
    for (int i = 0; i < 5; i++) begin
      run_op(1, tm[i], ta[i], tb[i], res, lat, stable, done_after, res_after);
      checks++;
      if (res !== te[i]) begin
        errors++; $display("FAIL corner%0d_result got=%h exp=%h", i, res, te[i]);
      end
      checks++;
      if (lat !== 9) begin
        errors++; $display("FAIL corner%0d_latency got=%0d exp=9", i, lat);
      end
      checks++;
      if (res_after !== te[i]) begin
        errors++; $display("FAIL corner%0d_hold got=%h exp=%h", i, res_after, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    start_v[1] = 1'b1; sm_v[1] = 1'b0; a_v[1] = 16'd3; b_v[1] = 16'd5;
    @(posedge clk); #1;
    a_v[1] = 16'd6; b_v[1] = 16'd7;
    t = 0;
    while (!d8 && t < 40) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (t !== 9) begin
      errors++; $display("FAIL b2b_first_latency got=%0d exp=9", t);
    end
    checks++;
    if (r8 !== 16'h000F) begin
      errors++; $display("FAIL b2b_first_result got=%h exp=000f", r8);
    end
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    checks++;
    if (d8 !== 1'b0 || y8 !== 1'b1) begin
      errors++; $display("FAIL b2b_accept got done=%b busy=%b exp done=0 busy=1", d8, y8);
    end
    t = 1;
    while (!d8 && t < 40) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (t !== 10) begin
      errors++; $display("FAIL b2b_done_spacing got=%0d exp=10", t);
    end
    checks++;
    if (r8 !== 16'h002A) begin
      errors++; $display("FAIL b2b_second_result got=%h exp=002a", r8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] res, res_after;
    int lat; bit stable; logic done_after;
    bit saw_done;
    start_v[1] = 1'b1; sm_v[1] = 1'b1; a_v[1] = 16'h0013; b_v[1] = 16'h00F1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    checks++;
    if (y8 !== 1'b0 || d8 !== 1'b0 || r8 !== 16'h0) begin
      errors++; $display("FAIL midrst_state got busy=%b done=%b result=%h exp 0/0/0000", y8, d8, r8);
    end
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (d8) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL midrst_no_done got=%b exp=0", saw_done);
    end
    run_op(1, 1'b1, 16'h0013, 16'h00F1, res, lat, stable, done_after, res_after);
    checks++;
    if (res !== ref_prod(8, 1'b1, 16'h0013, 16'h00F1)) begin
      errors++; $display("FAIL midrst_fresh got=%h exp=%h", res, ref_prod(8, 1'b1, 16'h0013, 16'h00F1));
    end
  endtask

  task automatic test_random(input int sel, input bit sm, input int n);
    logic [31:0] res, res_after, exp;
    logic [15:0] a, b;
    int lat, w; bit stable; logic done_after;
    w = width_of(sel);
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 10 == 0) a = (sel == 1) ? 16'h0080 : 16'h8000;
      exp = ref_prod(w, sm, a, b);
      run_op(sel, sm, a, b, res, lat, stable, done_after, res_after);
      checks++;
      if (res !== exp) begin
        errors++; $display("FAIL rand_w%0d_m%0d_result a=%h b=%h got=%h exp=%h", w, sm, a, b, res, exp);
      end
      checks++;
      if (lat !== w + 1) begin
        errors++; $display("FAIL rand_w%0d_m%0d_latency got=%0d exp=%0d", w, sm, lat, w + 1);
      end
      checks++;
      if (stable !== 1'b1) begin
        errors++; $display("FAIL rand_w%0d_m%0d_stable got=%b exp=1", w, sm, stable);
      end
      checks++;
      if (done_after !== 1'b0 || res_after !== exp) begin
        errors++; $display("FAIL rand_w%0d_m%0d_pulse got done=%b res=%h exp done=0 res=%h",
                           w, sm, done_after, res_after, exp);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < 3; s++) begin
      start_v[s] = 1'b0; sm_v[s] = 1'b0; a_v[s] = '0; b_v[s] = '0;
    end
    rstn = 1'b0;
    test_reset();
    test_w4_example();
    test_corners();
    test_back_to_back();
    test_reset_mid_run();
    test_random(1, 1'b0, 1000);
    test_random(1, 1'b1, 1000);
    test_random(2, 1'b0, 1000);
    test_random(2, 1'b1, 1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_signed.md
# mul_seq_signed

Parametrised sequential shift-and-add multiplier. It takes two WIDTH-bit operands on a start pulse and returns a 2*WIDTH-bit product after a fixed latency. A mode input selects signed (two's-complement) or unsigned operation. This block replaces the fixed 4-bit signed multiplier as the shared arithmetic unit for datapath blocks that can afford multi-cycle latency in exchange for area.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous, active-low reset, sampled on rising clk.
- start  input  1  request; sampled only while idle (busy=0).
- signed_mode  input  1  1 = two's-complement operands/result; 0 = unsigned; latched with operands.
- a  input  WIDTH  multiplicand; latched on accepted start.
- b  input  WIDTH  multiplier; latched on accepted start.
- result  output  2*WIDTH  product; updated only when done asserts, held otherwise.
- done  output  1  one-cycle pulse, result valid.
- busy  output  1  high from the edge after acceptance through the result-write edge.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**: on start=1, latch the following, then go to RUN:
  - mcand = |a| zero-extended to 2*WIDTH.
  - mplier = |b| (WIDTH bits).
  - neg = signed_mode & (a[MSB] ^ b[MSB]).
  - acc = 0.
  - cnt = WIDTH.
  - In unsigned mode the magnitudes are the raw operands.
- **RUN**, one iteration per cycle:
  - If mplier[0], acc += mcand.
  - mcand <<= 1, mplier >>= 1, cnt -= 1.
  - After the WIDTH-th iteration, go to FIX.
  - There is no early termination; latency is data-independent.
- **FIX**:
  - result <= neg ? -acc : acc (2*WIDTH two's complement).
  - done <= 1, busy <= 0, then go to IDLE.
- Width rules:
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH unsigned bits. No extra bit is needed.
  - acc is 2*WIDTH bits and never overflows in either mode (max (2^WIDTH-1)^2).
  - Negating 0 yields 0, so no -0 artefact.
- start is ignored while busy=1. Operand changes after acceptance have no effect.
- result is not cleared on start. It holds the previous product until the next done.
- Reset (rstn=0 at any rising edge, including mid-RUN):
  - state=IDLE, result=0, done=0, busy=0, internal registers cleared.
  - Any operation in flight is discarded with no done.

## Timing
- Edge 0: start=1 sampled in IDLE; busy=1 after edge 0.
- Edges 1..WIDTH: iterations. FIX is entered after edge WIDTH.
- Edge WIDTH+1: result written, done=1 and busy=0 after this edge.
- Latency from start edge to done visible is WIDTH+1 edges; throughput is one product per WIDTH+2 cycles.
- done deasserts after edge WIDTH+2.
- start high during the done cycle is accepted at edge WIDTH+2 (back-to-back allowed). done and busy are then 0 and 1 respectively after that edge.
- Reset values: result=0, done=0, busy=0.

## Structure
- Package mul_pkg holds:
  - State enum (IDLE, RUN, FIX).
  - Counter-width function: $clog2(WIDTH+1).
- Sub-module mul_mag (combinational, parameter WIDTH):
  - Inputs: value, signed_mode.
  - Outputs: magnitude and sign bit.
  - Instantiated twice, once for a and once for b.
- Final negation is done inline in FIX.

## Test plan
- WIDTH=4, signed: a=-3 (0xD), b=-7 (0x9) -> done after edge 5, result=0x15 (21).
- WIDTH=8, signed corners:
  - -128*-128 -> 0x4000.
  - -128*127 -> 0xC080 (-16256).
  - 0*-5 -> 0x0000.
- WIDTH=8, unsigned: 255*255 -> 0xFE01. The same bits in signed mode (-1*-1) -> 0x0001.
- Back-to-back: 3*5 then 6*7, with start held through the first done cycle.
  - Results 0x000F then 0x002A.
  - done pulses exactly WIDTH+2 cycles apart.
  - start pulses during busy are ignored.
- Reset mid-RUN: rstn=0 at iteration 3.
  - Next cycle: busy=0, done=0, result=0, and no done follows.
  - A fresh start afterwards gives the correct product.
- Randomised 1000 operations per mode at WIDTH=8 and WIDTH=16 against a reference product, checking latency and that result is stable between done pulses.
